// File: rtl/hal_register_pkg.sv
// Shared constants and helpers for the hal_register_init_value register chain.
// Optional feature macro used by the chain: KANAGAWA_HAL_REG_CE_EN (adds a clock enable).
package hal_register_pkg;

    // Default power-on / reset value. The chain casts it to its own WIDTH.
    localparam logic [63:0] HAL_REG_DEFAULT_INIT = '0;

    // A depth of zero turns the chain into a plain wire from data_in to data_out.
    function automatic bit hal_reg_is_passthrough(input int depth);
        return depth == 0;
    endfunction

endpackage : hal_register_pkg

// File: rtl/hal_register_init_value_stage.sv
// One register stage of the chain. The flop holds INIT_VAL from power-on.
// A synchronous active-low rst_n reloads INIT_VAL.
// With KANAGAWA_HAL_REG_CE_EN defined, a ce input gates capture. Reset ignores ce.
module hal_register_init_value_stage
    import hal_register_pkg::*;
#(
    parameter int              WIDTH    = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(HAL_REG_DEFAULT_INIT)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef KANAGAWA_HAL_REG_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    // NOTE: the declaration initialiser becomes the FPGA power-on value of the flop,
    // so the output is defined before any reset pulse arrives.
    logic [WIDTH-1:0] data_q = INIT_VAL;
    logic [WIDTH-1:0] data_d;

    // Next value: capture data_in, or hold when the clock enable is low.
    always_comb begin
`ifdef KANAGAWA_HAL_REG_CE_EN
        data_d = ce ? data_in : data_q;
`else
        data_d = data_in;
`endif
    end

    // State update. Reset is checked first, so it overrides both capture and ce.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment only.
        if (!rst_n) begin
            data_q <= INIT_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule : hal_register_init_value_stage

// File: rtl/hal_register_init_value.sv
// Chain of DEPTH register stages. Every stage powers up to INIT_VAL and reloads it on reset.
// With DEPTH == 0 the block is a combinational wire from data_in to data_out.
// Optional feature macro: KANAGAWA_HAL_REG_CE_EN adds a ce port that gates every stage.
module hal_register_init_value
    import hal_register_pkg::*;
#(
    parameter int               WIDTH    = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(HAL_REG_DEFAULT_INIT),
    parameter int               DEPTH    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef KANAGAWA_HAL_REG_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    localparam bit PASSTHROUGH = hal_reg_is_passthrough(DEPTH);

    // Stop elaboration on a parameter set that cannot describe a real chain.
    if (WIDTH < 1 || DEPTH < 0) begin : g_param_err
        $error("hal_register_init_value: WIDTH must be >= 1 and DEPTH must be >= 0");
    end

    if (PASSTHROUGH || DEPTH < 0) begin : g_passthrough
        // No stages: clk, rst_n and INIT_VAL play no part.
        assign data_out = data_in;
    end else begin : g_chain
        // Entry k is the input of stage k. The last entry is the chain output.
        logic [DEPTH:0][WIDTH-1:0] link;

        assign link[0] = data_in;

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            hal_register_init_value_stage #(
                .WIDTH    (WIDTH),
                .INIT_VAL (INIT_VAL)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
`ifdef KANAGAWA_HAL_REG_CE_EN
                .ce       (ce),
`endif
                .data_in  (link[k]),
                .data_out (link[k+1])
            );
        end

        assign data_out = link[DEPTH];
    end

endmodule : hal_register_init_value

// File: tb/tb_hal_register_init_value.sv
// Directed bench for hal_register_init_value. It covers power-on value, latency,
// reset mid-stream, passthrough and wide data. The clock-enable cases run only
// when KANAGAWA_HAL_REG_CE_EN is defined.
module tb_hal_register_init_value;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // u_a: WIDTH=8, DEPTH=1, INIT=A5
    logic       a_rst_n = 1'b1;
    logic [7:0] a_in    = 8'h00;
    logic [7:0] a_out;
    hal_register_init_value #(.WIDTH(8), .INIT_VAL(8'hA5), .DEPTH(1)) u_a (
        .clk(clk), .rst_n(a_rst_n),
`ifdef KANAGAWA_HAL_REG_CE_EN
        .ce(1'b1),
`endif
        .data_in(a_in), .data_out(a_out));

    // u_b: WIDTH=8, DEPTH=3, INIT=11 (latency)
    logic       b_rst_n = 1'b1;
    logic [7:0] b_in    = 8'h00;
    logic [7:0] b_out;
    hal_register_init_value #(.WIDTH(8), .INIT_VAL(8'h11), .DEPTH(3)) u_b (
        .clk(clk), .rst_n(b_rst_n),
`ifdef KANAGAWA_HAL_REG_CE_EN
        .ce(1'b1),
`endif
        .data_in(b_in), .data_out(b_out));

    // u_c: WIDTH=8, DEPTH=3, INIT=5A (reset mid-stream)
    logic       c_rst_n = 1'b1;
    logic [7:0] c_in    = 8'h00;
    logic [7:0] c_out;
    hal_register_init_value #(.WIDTH(8), .INIT_VAL(8'h5A), .DEPTH(3)) u_c (
        .clk(clk), .rst_n(c_rst_n),
`ifdef KANAGAWA_HAL_REG_CE_EN
        .ce(1'b1),
`endif
        .data_in(c_in), .data_out(c_out));

    // u_p: WIDTH=4, DEPTH=0 (passthrough)
    logic       p_rst_n = 1'b1;
    logic [3:0] p_in    = 4'h0;
    logic [3:0] p_out;
    hal_register_init_value #(.WIDTH(4), .INIT_VAL(4'h9), .DEPTH(0)) u_p (
        .clk(clk), .rst_n(p_rst_n),
`ifdef KANAGAWA_HAL_REG_CE_EN
        .ce(1'b1),
`endif
        .data_in(p_in), .data_out(p_out));

    // u_w: WIDTH=64, DEPTH=1, INIT=DEAD_BEEF_0123_4567
    localparam logic [63:0] W_INIT = 64'hDEAD_BEEF_0123_4567;
    logic        w_rst_n = 1'b1;
    logic [63:0] w_in    = 64'h0;
    logic [63:0] w_out;
    hal_register_init_value #(.WIDTH(64), .INIT_VAL(W_INIT), .DEPTH(1)) u_w (
        .clk(clk), .rst_n(w_rst_n),
`ifdef KANAGAWA_HAL_REG_CE_EN
        .ce(1'b1),
`endif
        .data_in(w_in), .data_out(w_out));

`ifdef KANAGAWA_HAL_REG_CE_EN
    // u_e: WIDTH=8, DEPTH=2, INIT=77 (clock enable)
    logic       e_rst_n = 1'b1;
    logic       e_ce    = 1'b0;
    logic [7:0] e_in    = 8'h00;
    logic [7:0] e_out;
    hal_register_init_value #(.WIDTH(8), .INIT_VAL(8'h77), .DEPTH(2)) u_e (
        .clk(clk), .rst_n(e_rst_n), .ce(e_ce),
        .data_in(e_in), .data_out(e_out));
`endif

    // One stream row: inputs for u_b/u_c before an edge, outputs expected after it.
    typedef struct {
        logic [7:0] b_in;
        logic [7:0] b_exp;
        logic       c_rst_n;
        logic [7:0] c_in;
        logic [7:0] c_exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // u_b has DEPTH=3: the value driven before edge n appears after edge n+2.
        // u_c gets reset at the 4th edge, so in-flight 02 and 03 are never seen.
        vecs[0] = '{8'h01, 8'h11, 1'b1, 8'h01, 8'h5A};
        vecs[1] = '{8'h02, 8'h11, 1'b1, 8'h02, 8'h5A};
        vecs[2] = '{8'h03, 8'h01, 1'b1, 8'h03, 8'h01};
        vecs[3] = '{8'h04, 8'h02, 1'b0, 8'h04, 8'h5A};
        vecs[4] = '{8'h05, 8'h03, 1'b1, 8'h05, 8'h5A};
        vecs[5] = '{8'h06, 8'h04, 1'b1, 8'h06, 8'h5A};
        vecs[6] = '{8'h07, 8'h05, 1'b1, 8'h07, 8'h05};
        vecs[7] = '{8'h08, 8'h06, 1'b1, 8'h08, 8'h06};

        // Power-on values, before any clock edge and with no reset.
        #1;
        check("poweron_a",   64'(a_out), 64'hA5);
        check("poweron_b",   64'(b_out), 64'h11);
        check("poweron_c",   64'(c_out), 64'h5A);
        check("poweron_w64", w_out,      W_INIT);
`ifdef KANAGAWA_HAL_REG_CE_EN
        check("poweron_e",   64'(e_out), 64'h77);
`endif

        // Streams for u_b and u_c. u_a captures 3C on the first edge.
        a_in = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            b_in    = vecs[i].b_in;
            c_in    = vecs[i].c_in;
            c_rst_n = vecs[i].c_rst_n;
            tick();
            if (i == 0) check("first_edge_a", 64'(a_out), 64'h3C);
            check($sformatf("latency_b[%0d]", i),  64'(b_out), 64'(vecs[i].b_exp));
            check($sformatf("reset_mid_c[%0d]", i), 64'(c_out), 64'(vecs[i].c_exp));
        end

        // Wide data: capture, then reset restores the init value bit-exact.
        w_in = 64'h0F0F_1234_5678_9ABC;
        tick();
        check("w64_capture", w_out, 64'h0F0F_1234_5678_9ABC);
        w_rst_n = 1'b0;
        w_in    = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        check("w64_reset", w_out, W_INIT);
        tick();
        check("w64_reset_hold", w_out, W_INIT);
        w_rst_n = 1'b1;
        #1;
        check("w64_release_before_edge", w_out, W_INIT);
        tick();
        check("w64_release_capture", w_out, 64'hFFFF_FFFF_FFFF_FFFF);

        // Passthrough: output follows input with no clock edge. Reset has no effect.
        @(negedge clk);
        p_in = 4'hF;
        #1 check("pass_f", 64'(p_out), 64'hF);
        p_in = 4'h0;
        #1 check("pass_0", 64'(p_out), 64'h0);
        p_rst_n = 1'b0;
        p_in    = 4'hF;
        #1 check("pass_rst_f", 64'(p_out), 64'hF);
        tick();
        check("pass_rst_after_edge", 64'(p_out), 64'hF);
        p_rst_n = 1'b1;

`ifdef KANAGAWA_HAL_REG_CE_EN
        // Load AA through the 2-stage chain.
        e_ce = 1'b1;
        e_in = 8'hAA;
        tick();
        e_in = 8'hBB;
        tick();
        check("ce_load", 64'(e_out), 64'hAA);
        // With ce low, the chain holds while data_in changes.
        e_ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e_in = 8'hC0 + 8'(i);
            tick();
            check($sformatf("ce_hold[%0d]", i), 64'(e_out), 64'hAA);
        end
        // Reset wins even with ce low.
        e_rst_n = 1'b0;
        tick();
        check("ce_reset", 64'(e_out), 64'h77);
        // Shift again with a 2-cycle latency.
        e_rst_n = 1'b1;
        e_ce    = 1'b1;
        e_in    = 8'h10;
        tick();
        check("ce_shift0", 64'(e_out), 64'h77);
        e_in = 8'h20;
        tick();
        check("ce_shift1", 64'(e_out), 64'h10);
        e_in = 8'h30;
        tick();
        check("ce_shift2", 64'(e_out), 64'h20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hal_register_init_value
